// File: rtl/mc_pkg.sv
// Shared encodings for the handshaking multicycle ARM controller: FSM state
// codes, ALU operations, datapath mux selects, opcode and condition fields.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTER = 4'd6,
    ST_EXECUTEI = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9
  } mc_state_e;

  // ALU operations (only the low three bits of ALUControl are meaningful)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  // ALUSrcA selects
  localparam logic [1:0] SRCA_AREG = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_WDATA  = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Op field values
  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Evaluate an ARM condition against {N,Z,C,V}; the 1111 encoding never passes.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n_s, z_s, c_s, v_s, ok_s;
    {n_s, z_s, c_s, v_s} = flags;
    case (cond)
      COND_EQ: ok_s = z_s;
      COND_NE: ok_s = ~z_s;
      COND_CS: ok_s = c_s;
      COND_CC: ok_s = ~c_s;
      COND_MI: ok_s = n_s;
      COND_PL: ok_s = ~n_s;
      COND_VS: ok_s = v_s;
      COND_VC: ok_s = ~v_s;
      COND_HI: ok_s = c_s & ~z_s;
      COND_LS: ok_s = ~c_s | z_s;
      COND_GE: ok_s = (n_s == v_s);
      COND_LT: ok_s = (n_s != v_s);
      COND_GT: ok_s = ~z_s & (n_s == v_s);
      COND_LE: ok_s = z_s | (n_s != v_s);
      COND_AL: ok_s = 1'b1;
      default: ok_s = 1'b0;
    endcase
    return ok_s;
  endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// Conditional-execution unit: holds the architectural NZCV flags and the
// per-instruction condition result sampled in DECODE.
module mc_cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       latch_en,
  input  logic       update_en,
  output logic       condex_q
);

  logic [3:0] flags_r;
  logic       condex_r;

  // Sample the condition in DECODE; capture N,Z and C,V separately after a passing ALU op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r  <= 4'b0000;
      condex_r <= 1'b0;
    end else begin
      if (latch_en) begin
        condex_r <= cond_check(cond, flags_r);
      end
      if (update_en && condex_r) begin
        if (flag_w[1]) begin
          flags_r[3:2] <= alu_flags[3:2];
        end
        if (flag_w[0]) begin
          flags_r[1:0] <= alu_flags[1:0];
        end
      end
    end
  end

  assign condex_q = condex_r;

endmodule

// File: rtl/mc_controller_hs.sv
// Multicycle ARM controller with memory-ready handshake, compare-only
// instructions, illegal-encoding detection and a visible state code.
module mc_controller_hs
  import mc_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 IllegalInstr,
  output logic [3:0]           State
);

  mc_state_e state_r;

  logic [3:0] cond_s;
  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic [3:0] cmd_s;
  logic       s_bit_s;
  logic [3:0] rd_s;
  logic       unused_rn_s;
  logic       mem_ready_s;

  logic [2:0] alu_op_s;
  logic       arith_s;
  logic       no_write_s;
  logic       dp_legal_s;
  logic       illegal_s;
  logic [1:0] flag_w_s;

  logic       next_pc_s;
  logic       branch_s;
  logic       reg_w_s;
  logic       mem_w_s;
  logic       ir_write_s;
  logic       illegal_pulse_s;
  logic       adr_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] result_src_s;
  logic [2:0] alu_sel_s;
  logic       pcs_s;
  logic       condex_s;

  assign cond_s      = Instr[19:16];
  assign op_s        = Instr[15:14];
  assign funct_s     = Instr[13:8];
  assign cmd_s       = funct_s[4:1];
  assign s_bit_s     = funct_s[0];
  assign rd_s        = Instr[3:0];
  assign unused_rn_s = ^Instr[7:4];

  // Without the handshake every memory access completes in one cycle.
  assign mem_ready_s = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  // ALU decoder: op, flag classes and legality of the data-processing command.
  always_comb begin
    alu_op_s   = ALU_ADD;
    arith_s    = 1'b0;
    no_write_s = 1'b0;
    dp_legal_s = 1'b1;
    case (cmd_s)
      4'b0100: begin alu_op_s = ALU_ADD; arith_s = 1'b1; end
      4'b0010: begin alu_op_s = ALU_SUB; arith_s = 1'b1; end
      4'b0000: alu_op_s = ALU_AND;
      4'b1100: alu_op_s = ALU_ORR;
      4'b0001: alu_op_s = ALU_EOR;
      // Compares only make sense when they set flags
      4'b1010: begin alu_op_s = ALU_SUB; arith_s = 1'b1; no_write_s = 1'b1; dp_legal_s = s_bit_s; end
      4'b1011: begin alu_op_s = ALU_ADD; arith_s = 1'b1; no_write_s = 1'b1; dp_legal_s = s_bit_s; end
      4'b1000: begin alu_op_s = ALU_AND; no_write_s = 1'b1; dp_legal_s = s_bit_s; end
      default: dp_legal_s = 1'b0;
    endcase
  end

  assign illegal_s = (op_s == OP_RSVD) | ((op_s == OP_DP) & ~dp_legal_s);
  assign flag_w_s  = {s_bit_s, s_bit_s & arith_s};

  // State register and transitions, including the memory wait states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH:    state_r <= mem_ready_s ? ST_DECODE : ST_FETCH;
        ST_DECODE: begin
          case (op_s)
            OP_MEM:  state_r <= ST_MEMADR;
            OP_BR:   state_r <= ST_BRANCH;
            OP_DP:   state_r <= illegal_s ? ST_FETCH :
                                (funct_s[5] ? ST_EXECUTEI : ST_EXECUTER);
            default: state_r <= ST_FETCH;
          endcase
        end
        ST_MEMADR:   state_r <= funct_s[0] ? ST_MEMREAD : ST_MEMWRITE;
        ST_MEMREAD:  state_r <= mem_ready_s ? ST_MEMWB : ST_MEMREAD;
        ST_MEMWB:    state_r <= ST_FETCH;
        ST_MEMWRITE: state_r <= mem_ready_s ? ST_FETCH : ST_MEMWRITE;
        ST_EXECUTER: state_r <= no_write_s ? ST_FETCH : ST_ALUWB;
        ST_EXECUTEI: state_r <= no_write_s ? ST_FETCH : ST_ALUWB;
        ST_ALUWB:    state_r <= ST_FETCH;
        ST_BRANCH:   state_r <= ST_FETCH;
        default:     state_r <= ST_FETCH;
      endcase
    end
  end

  // Per-state datapath controls; write intents are qualified further below.
  always_comb begin
    next_pc_s       = 1'b0;
    branch_s        = 1'b0;
    reg_w_s         = 1'b0;
    mem_w_s         = 1'b0;
    ir_write_s      = 1'b0;
    illegal_pulse_s = 1'b0;
    adr_src_s       = 1'b0;
    alu_src_a_s     = SRCA_AREG;
    alu_src_b_s     = SRCB_WDATA;
    result_src_s    = RES_ALUOUT;
    alu_sel_s       = ALU_ADD;
    case (state_r)
      ST_FETCH: begin
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
        ir_write_s   = mem_ready_s;
        next_pc_s    = mem_ready_s;
      end
      ST_DECODE: begin
        alu_src_a_s     = SRCA_PC;
        alu_src_b_s     = SRCB_FOUR;
        result_src_s    = RES_ALURESULT;
        illegal_pulse_s = illegal_s;
      end
      ST_MEMADR: begin
        alu_src_b_s = SRCB_EXTIMM;
      end
      ST_MEMREAD: begin
        adr_src_s = 1'b1;
      end
      ST_MEMWB: begin
        result_src_s = RES_DATA;
        reg_w_s      = 1'b1;
      end
      ST_MEMWRITE: begin
        adr_src_s = 1'b1;
        mem_w_s   = 1'b1;
      end
      ST_EXECUTER: begin
        alu_sel_s = alu_op_s;
      end
      ST_EXECUTEI: begin
        alu_src_b_s = SRCB_EXTIMM;
        alu_sel_s   = alu_op_s;
      end
      ST_ALUWB: begin
        result_src_s = RES_ALUOUT;
        reg_w_s      = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_b_s  = SRCB_EXTIMM;
        result_src_s = RES_ALURESULT;
        branch_s     = 1'b1;
      end
      default: begin
        next_pc_s = 1'b0;
      end
    endcase
  end

  mc_cond_unit u_cond (
    .clk       (clk),
    .rst_n     (reset),
    .cond      (cond_s),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w_s),
    .latch_en  (state_r == ST_DECODE),
    .update_en ((state_r == ST_EXECUTER) || (state_r == ST_EXECUTEI)),
    .condex_q  (condex_s)
  );

  // A register write to R15 is a PC write as well.
  assign pcs_s = branch_s | (reg_w_s & (rd_s == 4'hF));

  // Enables are held low for as long as reset is asserted.
  assign PCWrite      = reset & (next_pc_s | (pcs_s & condex_s));
  assign RegWrite     = reset & reg_w_s & condex_s;
  assign MemWrite     = reset & mem_w_s & condex_s & (state_r == ST_MEMWRITE);
  assign IRWrite      = reset & ir_write_s;
  assign IllegalInstr = reset & illegal_pulse_s;

  assign AdrSrc     = adr_src_s;
  assign RegSrc     = {op_s == OP_MEM, op_s == OP_BR};
  assign ALUSrcA    = alu_src_a_s;
  assign ALUSrcB    = alu_src_b_s;
  assign ResultSrc  = result_src_s;
  assign ImmSrc     = op_s;
  assign ALUControl = ALUCTRL_W'(alu_sel_s);
  assign State      = state_r;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Scoreboard bench for mc_controller_hs: each driven cycle pushes the
// expected state and enables, and a monitor pops and compares mid-cycle.
module tb_mc_controller_hs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = 20'h00000;
  logic [3:0]  ALUFlags = 4'b0000;
  logic        MemReady = 1'b1;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, IllegalInstr;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  mc_controller_hs #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .Instr        (Instr),
    .ALUFlags     (ALUFlags),
    .MemReady     (MemReady),
    .PCWrite      (PCWrite),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .IRWrite      (IRWrite),
    .AdrSrc       (AdrSrc),
    .RegSrc       (RegSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ResultSrc    (ResultSrc),
    .ImmSrc       (ImmSrc),
    .ALUControl   (ALUControl),
    .IllegalInstr (IllegalInstr),
    .State        (State)
  );

  always #5 clk = ~clk;

  // en = {PCWrite, IRWrite, RegWrite, MemWrite, IllegalInstr}; res/alu < 0 = not checked
  typedef struct {
    logic [3:0] st;
    logic [4:0] en;
    int         res;
    int         alu;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
  endtask

  // Drive one cycle of inputs on the falling edge and record what it should produce.
  task automatic cyc(input logic rst, input logic [19:0] ins, input logic [3:0] fl,
                     input logic rdy, input logic [3:0] st, input logic [4:0] en,
                     input int res, input int alu);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    Instr    = ins;
    ALUFlags = fl;
    MemReady = rdy;
    e.st = st; e.en = en; e.res = res; e.alu = alu;
    sb_q.push_back(e);
  endtask

  // Monitor: compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    #3;
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq("State",        32'(State),        32'(e.st));
        check_eq("PCWrite",      32'(PCWrite),      32'(e.en[4]));
        check_eq("IRWrite",      32'(IRWrite),      32'(e.en[3]));
        check_eq("RegWrite",     32'(RegWrite),     32'(e.en[2]));
        check_eq("MemWrite",     32'(MemWrite),     32'(e.en[1]));
        check_eq("IllegalInstr", 32'(IllegalInstr), 32'(e.en[0]));
        if (e.res >= 0) check_eq("ResultSrc",  32'(ResultSrc),  32'(e.res));
        if (e.alu >= 0) check_eq("ALUControl", 32'(ALUControl), 32'(e.alu));
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    mon_en = 1'b1;
    // Reset held two cycles: FETCH decode, all enables low
    cyc(1'b0, 20'h00000, 4'h0, 1'b1, 4'd0, 5'b00000, 2, 0);
    cyc(1'b0, 20'h00000, 4'h0, 1'b1, 4'd0, 5'b00000, 2, 0);
    // ADD R1,R2,R3
    cyc(1'b1, 20'hE0821, 4'h0, 1'b1, 4'd0, 5'b11000, 2, 0);
    cyc(1'b1, 20'hE0821, 4'h0, 1'b1, 4'd1, 5'b00000, 2, -1);
    cyc(1'b1, 20'hE0821, 4'h0, 1'b1, 4'd6, 5'b00000, -1, 0);
    cyc(1'b1, 20'hE0821, 4'h0, 1'b1, 4'd8, 5'b00100, 0, -1);
    // FETCH waits for memory, then LDR with two MEMREAD wait cycles
    cyc(1'b1, 20'hE5921, 4'h0, 1'b0, 4'd0, 5'b00000, 2, -1);
    cyc(1'b1, 20'hE5921, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hE5921, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE5921, 4'h0, 1'b1, 4'd2, 5'b00000, -1, 0);
    cyc(1'b1, 20'hE5921, 4'h0, 1'b0, 4'd3, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE5921, 4'h0, 1'b0, 4'd3, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE5921, 4'h0, 1'b1, 4'd3, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE5921, 4'h0, 1'b1, 4'd4, 5'b00100, 1, -1);
    // STR with one MEMWRITE wait: MemWrite held throughout
    cyc(1'b1, 20'hE5821, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hE5821, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE5821, 4'h0, 1'b1, 4'd2, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE5821, 4'h0, 1'b0, 4'd5, 5'b00010, -1, -1);
    cyc(1'b1, 20'hE5821, 4'h0, 1'b1, 4'd5, 5'b00010, -1, -1);
    // SUBS producing Z=1, then ADDEQ executes
    cyc(1'b1, 20'hE0521, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hE0521, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE0521, 4'h4, 1'b1, 4'd6, 5'b00000, -1, 1);
    cyc(1'b1, 20'hE0521, 4'h0, 1'b1, 4'd8, 5'b00100, 0, -1);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd6, 5'b00000, -1, 0);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd8, 5'b00100, 0, -1);
    // SUBS producing Z=0, then ADDEQ is suppressed
    cyc(1'b1, 20'hE0521, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hE0521, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE0521, 4'h0, 1'b1, 4'd6, 5'b00000, -1, 1);
    cyc(1'b1, 20'hE0521, 4'h0, 1'b1, 4'd8, 5'b00100, 0, -1);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd6, 5'b00000, -1, 0);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd8, 5'b00000, 0, -1);
    // CMP latches Z=1 without writeback; following ADDEQ executes
    cyc(1'b1, 20'hE1500, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hE1500, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE1500, 4'h4, 1'b1, 4'd6, 5'b00000, -1, 1);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd6, 5'b00000, -1, 0);
    cyc(1'b1, 20'h00821, 4'h0, 1'b1, 4'd8, 5'b00100, 0, -1);
    // Op=11 and CMP without S are illegal: pulse in DECODE, back to FETCH
    cyc(1'b1, 20'hEC000, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hEC000, 4'h0, 1'b1, 4'd1, 5'b00001, -1, -1);
    cyc(1'b1, 20'hE1400, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hE1400, 4'h0, 1'b1, 4'd1, 5'b00001, -1, -1);
    // Branch always, then branch with the never-true condition
    cyc(1'b1, 20'hEA000, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hEA000, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'hEA000, 4'h0, 1'b1, 4'd9, 5'b10000, 2, 0);
    cyc(1'b1, 20'hFA000, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hFA000, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'hFA000, 4'h0, 1'b1, 4'd9, 5'b00000, 2, 0);
    // ADD into R15 also writes the PC
    cyc(1'b1, 20'hE080F, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hE080F, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE080F, 4'h0, 1'b1, 4'd6, 5'b00000, -1, 0);
    cyc(1'b1, 20'hE080F, 4'h0, 1'b1, 4'd8, 5'b10100, 0, -1);
    // Immediate ADD goes through EXECUTEI
    cyc(1'b1, 20'hE2821, 4'h0, 1'b1, 4'd0, 5'b11000, 2, -1);
    cyc(1'b1, 20'hE2821, 4'h0, 1'b1, 4'd1, 5'b00000, -1, -1);
    cyc(1'b1, 20'hE2821, 4'h0, 1'b1, 4'd7, 5'b00000, -1, 0);
    cyc(1'b1, 20'hE2821, 4'h0, 1'b1, 4'd8, 5'b00100, 0, -1);
    cyc(1'b1, 20'h00000, 4'h0, 1'b1, 4'd0, 5'b11000, 2, 0);
    #5;
    mon_en = 1'b0;
    if (sb_q.size() != 0) check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
